test_seq_ctrl: RTL

- Synthesizable test sequencer that drives the method-call handshake (`*_req` / `*_busy` / `*_return`) of N compiled test modules, one after another.
- Sits directly upstream of the generated test modules. It replaces per-test simulation benches with one on-chip runner that reports pass, fail and timeout per test.
- Its results feed a status register or LED block.

---
 rtl/test_seq_pkg.sv | 17 +
 rtl/test_seq_timer.sv | 23 ++
 rtl/test_seq_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/test_seq_pkg.sv
// Shared definitions for the on-chip test sequencer: one-hot state codes and
// default timing constants.
package test_seq_pkg;

   // One-hot state codes; anything else is treated as corrupt and recovers to S_IDLE.
   localparam logic [5:0] S_IDLE   = 6'b000001;
   localparam logic [5:0] S_ISSUE  = 6'b000010;
   localparam logic [5:0] S_SETTLE = 6'b000100;
   localparam logic [5:0] S_WAIT   = 6'b001000;
   localparam logic [5:0] S_NEXT   = 6'b010000;
   localparam logic [5:0] S_DONE   = 6'b100000;

   localparam int unsigned DEF_START_DELAY = 100;
   localparam int unsigned DEF_SETTLE      = 5;
   localparam int unsigned DEF_TIMEOUT     = 1000000;

endpackage

// File: rtl/test_seq_timer.sv
// Saturating 32-bit cycle counter with synchronous clear/enable and a
// "value has reached limit" flag.
module test_seq_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        en,
   input  logic [31:0] limit,
   output logic [31:0] value,
   output logic        reached
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         value <= '0;
      end else if (en && (value != '1)) begin
         value <= value + 32'd1;
      end
   end

   assign reached = (value >= limit);

endmodule

// File: rtl/test_seq_ctrl.sv
// Sequencer that issues req/busy/return handshakes to N compiled test modules
// in order and records pass, timeout and elapsed cycles per test.
module test_seq_ctrl
   import test_seq_pkg::*;
#(
   parameter int unsigned N_TESTS     = 4,
   parameter int unsigned START_DELAY = DEF_START_DELAY,
   parameter int unsigned SETTLE      = DEF_SETTLE,   // must be >= 1
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT,  // must exceed SETTLE
   parameter int unsigned IDX_W       = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic [N_TESTS-1:0] test_req,
   input  logic [N_TESTS-1:0] test_busy,
   input  logic [N_TESTS-1:0] test_return,
   output logic [IDX_W-1:0]   cur_index,
   output logic               done,
   output logic               all_pass,
   output logic [N_TESTS-1:0] pass_mask,
   output logic [N_TESTS-1:0] timeout_mask,
   output logic [31:0]        elapsed
);

   localparam logic [31:0]      DELAY_LIM  = 32'(START_DELAY);
   localparam logic [31:0]      SETTLE_LIM = 32'(SETTLE - 1);
   localparam logic [31:0]      TMO_LIM    = 32'(TIMEOUT - 1);
   localparam logic [31:0]      TMO_VAL    = 32'(TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_TESTS - 1);

   logic [5:0]         state;
   logic [N_TESTS-1:0] cur_onehot;
   logic               cur_busy;
   logic               cur_return;

   logic               delay_en;
   logic               delay_reached;
   logic [31:0]        delay_value;

   logic               tmr_clr;
   logic               tmr_en;
   logic               tmr_reached;
   logic [31:0]        tmr_limit;
   logic [31:0]        tmr_value;

   // Only the current test's busy/return bits are observed.
   assign cur_onehot = N_TESTS'(1) << cur_index;
   assign cur_busy   = |(test_busy & cur_onehot);
   assign cur_return = |(test_return & cur_onehot);

   assign test_req = (state == S_ISSUE) ? cur_onehot : '0;
   assign done     = (state == S_DONE);
   assign all_pass = done && (&pass_mask) && (timeout_mask == '0);

   assign delay_en = (state == S_IDLE) && (delay_value < DELAY_LIM);

   test_seq_timer u_delay_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (1'b0),
      .en      (delay_en),
      .limit   (DELAY_LIM),
      .value   (delay_value),
      .reached (delay_reached)
   );

   // One timer spans settle and wait, so its value is cycles since the request.
   assign tmr_clr   = (state == S_ISSUE);
   assign tmr_en    = (state == S_SETTLE) || (state == S_WAIT);
   assign tmr_limit = (state == S_SETTLE) ? SETTLE_LIM : TMO_LIM;

   test_seq_timer u_test_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .limit   (tmr_limit),
      .value   (tmr_value),
      .reached (tmr_reached)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         cur_index    <= '0;
         pass_mask    <= '0;
         timeout_mask <= '0;
         elapsed      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (delay_reached && start) state <= S_ISSUE;
            end
            S_ISSUE: begin
               state <= S_SETTLE;
            end
            S_SETTLE: begin
               if (tmr_reached) state <= S_WAIT;
            end
            S_WAIT: begin
               // Busy low wins over a timeout expiring in the same cycle.
               if (!cur_busy) begin
                  pass_mask <= (pass_mask & ~cur_onehot) | (cur_return ? cur_onehot : '0);
                  elapsed   <= tmr_value;
                  state     <= S_NEXT;
               end else if (tmr_reached) begin
                  timeout_mask <= timeout_mask | cur_onehot;
                  pass_mask    <= pass_mask & ~cur_onehot;
                  elapsed      <= TMO_VAL;
                  state        <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (cur_index == LAST_IDX) begin
                  state <= S_DONE;
               end else begin
                  cur_index <= cur_index + 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state     <= S_IDLE;
               cur_index <= '0;
            end
         endcase
      end
   end

endmodule
